// File: rtl/output_uart.sv
// rtl/output_uart.sv - 16-bit word FIFO feeding an 8N1 UART transmitter, low byte first.
// Writes that find the FIFO full are dropped and latched into a sticky overflow flag.
module output_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] output_val,
    input  logic        output_enable,
    output logic        uart_tx,
    output logic        fifo_full,
    output logic        overflow,
    output logic        busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [15:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    state_t            r_state;
    logic              r_byte_sel;
    logic [2:0]        r_bit_idx;
    logic [BAUD_W-1:0] r_baud;
    logic [15:0]       r_shift_word;
    logic              r_tx;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_baud_done;
    logic [7:0]        w_cur_byte;

    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    // Full is judged on the registered count, so a same-edge pop never rescues a write.
    assign w_push      = output_enable & ~w_full;
    assign w_pop       = (r_state == S_IDLE) & ~w_empty;
    assign w_baud_done = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_cur_byte  = r_byte_sel ? r_shift_word[15:8] : r_shift_word[7:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= output_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (output_enable && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // r_tx is loaded with the level of the state being entered, so the line is a clean register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_byte_sel   <= 1'b0;
            r_bit_idx    <= '0;
            r_baud       <= '0;
            r_shift_word <= '0;
            r_tx         <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (!w_empty) begin
                        r_shift_word <= r_mem[r_rd_ptr];
                        r_byte_sel   <= 1'b0;
                        r_state      <= S_START;
                        r_tx         <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                        r_tx      <= w_cur_byte[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_cur_byte[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (!r_byte_sel) begin
                            r_byte_sel <= 1'b1;
                            r_state    <= S_START;
                            r_tx       <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx   = r_tx;
    assign fifo_full = w_full;
    assign overflow  = r_overflow;
    assign busy      = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: tb/tb_output_uart.sv
// tb/tb_output_uart.sv - scoreboard bench for output_uart with a word-level timing model.
// A UART receiver on the line pops expected bytes and their start cycles from the scoreboard.
module tb_output_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int HB    = CPB / 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] output_val = '0;
    logic        output_enable = 1'b0;
    logic        uart_tx;
    logic        fifo_full;
    logic        overflow;
    logic        busy;

    output_uart #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .output_val   (output_val),
        .output_enable(output_enable),
        .uart_tx      (uart_tx),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_idle_edge = 0;
    logic [15:0] m_q[$];
    logic        m_ovf = 1'b0;
    logic        m_full_now;
    logic [15:0] m_w;
    exp_t        sbq[$];
    exp_t        e_item;

    logic        rx_active = 1'b0;
    int          rx_cnt = 0;
    int          rx_start = 0;
    logic [7:0]  rx_byte = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Word-level model: a word leaves the FIFO when the line has been free for its idle clk,
    // then occupies 20 bit times; bytes are expected at fixed offsets from the pop edge.
    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            sbq.delete();
            m_idle_edge = 0;
            m_ovf       = 1'b0;
        end else begin
            m_full_now = (m_q.size() == DEPTH);
            if (cyc >= m_idle_edge && m_q.size() > 0) begin
                m_w = m_q.pop_front();
                sbq.push_back('{m_w[7:0], cyc + 1});
                sbq.push_back('{m_w[15:8], cyc + 1 + 10 * CPB});
                m_idle_edge = cyc + 20 * CPB + 1;
            end
            if (output_enable) begin
                if (m_full_now) m_ovf = 1'b1;
                else m_q.push_back(output_val);
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (reset) begin
            rx_active = 1'b0;
        end else begin
            check("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("busy", 32'(busy), 32'((cyc < m_idle_edge) || (m_q.size() > 0)));
            if (!rx_active) begin
                if (uart_tx !== 1'b1) begin
                    check("start_expected", 32'(sbq.size() > 0), 32'd1);
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                    rx_start  = cyc;
                    rx_byte   = '0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == HB) begin
                    check("start_bit", 32'(uart_tx), 32'd0);
                end else if (rx_cnt > HB && rx_cnt <= HB + 8 * CPB && ((rx_cnt - HB) % CPB) == 0) begin
                    rx_byte[3'((rx_cnt - HB) / CPB - 1)] = uart_tx;
                end else if (rx_cnt == HB + 9 * CPB) begin
                    check("stop_bit", 32'(uart_tx), 32'd1);
                    check("byte_expected", 32'(sbq.size() > 0), 32'd1);
                    if (sbq.size() > 0) begin
                        e_item = sbq.pop_front();
                        check("rx_byte", 32'(rx_byte), 32'(e_item.b));
                        check("start_cycle", 32'(rx_start), 32'(e_item.start));
                    end
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [15:0] v);
        output_enable = 1'b1;
        output_val    = v;
        tick();
        output_enable = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while ((m_q.size() > 0 || sbq.size() > 0 || rx_active || cyc <= m_idle_edge) && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(k < budget), 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        // 1: quiet line
        repeat (100) tick();
        check("t1_tx", 32'(uart_tx), 32'd1);

        // 2: single word
        write(16'hA55A);
        drain("t2_drain", 200);

        // 3: three back-to-back strobes
        write(16'h0001);
        write(16'h0203);
        write(16'h0405);
        drain("t3_drain", 400);
        check("t3_ovf", 32'(overflow), 32'd0);

        // 4: burst of twelve into an idle transmitter
        for (int i = 0; i < 12; i++) write(16'(i));
        check("t4_ovf", 32'(overflow), 32'd1);
        drain("t4_drain", 1200);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);

        // 5: reset in the middle of byte 0 data bits
        write(16'h1234);
        repeat (1 + 4 * CPB) tick();
        #2;
        reset = 1'b1;
        #1;
        check("t5_tx_async", 32'(uart_tx), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_full", 32'(fifo_full), 32'd0);
        check("t5_ovf", 32'(overflow), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        write(16'h00FF);
        drain("t5_drain", 200);

        // 6: push coinciding with the IDLE pop at count DEPTH-1
        write(16'h1111);
        for (int i = 0; i < DEPTH - 1; i++) write(16'h2000 + 16'(i));
        begin
            int k = 0;
            while (cyc != m_idle_edge && k < 200) begin
                tick();
                k++;
            end
            check("t6_align", 32'(k < 200), 32'd1);
        end
        write(16'h7777);
        check("t6_full", 32'(fifo_full), 32'd0);
        drain("t6_drain", 1200);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                for (int j = 0; j < 10; j++) write(16'($urandom));
            end else if ($urandom_range(0, 99) < 2) begin
                write(16'($urandom));
            end else begin
                tick();
            end
        end
        drain("rand_drain", 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
